// File: rtl/prg_loader.sv
// PRG file loader: streams a downloaded PRG image into RAM over a DMA port
// while holding the CPU, then patches the BASIC end-of-program pointers.
module prg_loader #(
  parameter logic [13:0] PTR_BASE  = 14'h002A,
  parameter int unsigned PTR_COUNT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_valid,
  input  logic [7:0]  dl_data,
  output logic        dl_ready,
  output logic [13:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned RAM_W  = 14;
  localparam int unsigned IDX_W  = 3;
  localparam logic [ADDR_W-1:0] RAM_TOP  = 16'h3FFF;
  localparam logic [ADDR_W-1:0] ADDR_MAX = 16'hFFFF;
  localparam logic [IDX_W-1:0]  PTR_LAST = IDX_W'((PTR_COUNT == 0) ? 0 : 2 * PTR_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_PTR, S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [IDX_W-1:0]   ptr_idx_q, ptr_idx_d;
  logic               active_q;
  logic               accept;
  logic               dl_ready_d, dma_we_d, cpu_hold_d, done_d, err_d;
  logic [RAM_W-1:0]   dma_addr_d;
  logic [7:0]         dma_din_d;

  assign accept = dl_valid & dl_ready;

  // State and registered outputs; active_q resets high so a level already
  // high at reset release is not mistaken for a new download.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      ptr_idx_q <= '0;
      active_q  <= 1'b1;
      dl_ready  <= 1'b0;
      dma_addr  <= '0;
      dma_din   <= '0;
      dma_we    <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ptr_idx_q <= ptr_idx_d;
      active_q  <= dl_active;
      dl_ready  <= dl_ready_d;
      dma_addr  <= dma_addr_d;
      dma_din   <= dma_din_d;
      dma_we    <= dma_we_d;
      cpu_hold  <= cpu_hold_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ptr_idx_d  = ptr_idx_q;
    dma_addr_d = dma_addr;
    dma_din_d  = dma_din;
    dma_we_d   = 1'b0;
    err_d      = err;

    case (state_q)
      S_IDLE: begin
        ptr_idx_d = '0;
        if (dl_active && !active_q) begin
          state_d = S_HDR_LO;
          err_d   = 1'b0;
        end
      end
      S_HDR_LO: begin
        if (!dl_active) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else if (accept) begin
          addr_d[7:0] = dl_data;
          state_d     = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (!dl_active) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else if (accept) begin
          addr_d[15:8] = dl_data;
          state_d      = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (addr_q <= RAM_TOP) begin
            dma_we_d   = 1'b1;
            dma_addr_d = addr_q[RAM_W-1:0];
            dma_din_d  = dl_data;
          end else begin
            err_d = 1'b1;
          end
          if (addr_q == ADDR_MAX) err_d = 1'b1;
          else addr_d = addr_q + 16'd1;
        end
        // A write accepted this cycle is already registered, so it issues
        // before the first pointer write.
        if (!dl_active) state_d = S_PTR;
      end
      S_PTR: begin
        if (PTR_COUNT == 0 || err) begin
          state_d = S_FIN;
        end else begin
          dma_we_d   = 1'b1;
          dma_addr_d = PTR_BASE + RAM_W'(ptr_idx_q);
          dma_din_d  = ptr_idx_q[0] ? addr_q[15:8] : addr_q[7:0];
          ptr_idx_d  = ptr_idx_q + 3'd1;
          if (ptr_idx_q == PTR_LAST) state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it
    cpu_hold_d = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d     = (state_d == S_FIN);
    dl_ready_d = dl_active &&
                 ((state_d == S_HDR_LO) || (state_d == S_HDR_HI) || (state_d == S_DATA));
  end

endmodule

// File: tb/tb_prg_loader.sv
// Scoreboard bench for prg_loader: two instances (PTR_COUNT 3 and 0) share
// the download stream; expected RAM writes and done events come from a file-level model.
module tb_prg_loader;

  localparam logic [13:0] PTR_BASE = 14'h002A;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dl_active, dl_valid;
  logic [7:0]  dl_data;
  logic        rdy_a, we_a, hold_a, done_a, err_a;
  logic [13:0] addr_a;
  logic [7:0]  din_a;
  logic        rdy_b, we_b, hold_b, done_b, err_b;
  logic [13:0] addr_b;
  logic [7:0]  din_b;

  always #5 clk = ~clk;

  prg_loader #(.PTR_BASE(PTR_BASE), .PTR_COUNT(3)) dut_a (
    .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_valid(dl_valid),
    .dl_data(dl_data), .dl_ready(rdy_a), .dma_addr(addr_a), .dma_din(din_a),
    .dma_we(we_a), .cpu_hold(hold_a), .done(done_a), .err(err_a));

  prg_loader #(.PTR_BASE(PTR_BASE), .PTR_COUNT(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_valid(dl_valid),
    .dl_data(dl_data), .dl_ready(rdy_b), .dma_addr(addr_b), .dma_din(din_b),
    .dma_we(we_b), .cpu_hold(hold_b), .done(done_b), .err(err_b));

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t  exp_wr_a[$], exp_wr_b[$];
  logic exp_done_a[$], exp_done_b[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Expected writes and completion for a whole file, from the PRG rules
  task automatic model(input int inst, input logic [7:0] file[$]);
    int   pc = (inst == 0) ? 3 : 0;
    bit   e = 1'b0;
    int   la, n, a, endv;
    wr_t  w;
    if (file.size() < 2) begin
      e = 1'b1;
    end else begin
      la = int'({file[1], file[0]});
      n  = file.size() - 2;
      for (int i = 0; i < n; i++) begin
        a = la + i;
        if (a <= 'h3FFF) begin
          w.addr = 14'(a);
          w.data = file[i+2];
          if (inst == 0) exp_wr_a.push_back(w); else exp_wr_b.push_back(w);
        end else begin
          e = 1'b1;
        end
      end
      endv = (la + n > 'hFFFF) ? 'hFFFF : la + n;
      if (!e) begin
        for (int k = 0; k < 2 * pc; k++) begin
          w.addr = PTR_BASE + 14'(k);
          w.data = (k % 2 == 0) ? 8'(endv) : 8'(endv >> 8);
          exp_wr_a.push_back(w);
        end
      end
    end
    if (inst == 0) exp_done_a.push_back(e); else exp_done_b.push_back(e);
  endtask

  task automatic mon(input int inst, input logic we, input logic [13:0] a,
                     input logic [7:0] d, input logic dn, input logic e, input logic h);
    wr_t  w;
    logic ee;
    if (we) begin
      if ((inst == 0 ? exp_wr_a.size() : exp_wr_b.size()) == 0) begin
        fail($sformatf("unexpected_write%0d addr=%0h", inst, a));
      end else begin
        w = (inst == 0) ? exp_wr_a.pop_front() : exp_wr_b.pop_front();
        check($sformatf("wr_addr%0d", inst), 32'(a), 32'(w.addr));
        check($sformatf("wr_data%0d@%0h", inst, w.addr), 32'(d), 32'(w.data));
      end
    end
    if (dn) begin
      if ((inst == 0 ? exp_done_a.size() : exp_done_b.size()) == 0) begin
        fail($sformatf("unexpected_done%0d", inst));
      end else begin
        ee = (inst == 0) ? exp_done_a.pop_front() : exp_done_b.pop_front();
        check($sformatf("done_err%0d", inst), 32'(e), 32'(ee));
        check($sformatf("done_hold%0d", inst), 32'(h), 32'd0);
        check($sformatf("done_wr_left%0d", inst),
              (inst == 0) ? exp_wr_a.size() : exp_wr_b.size(), 0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon(0, we_a, addr_a, din_a, done_a, err_a, hold_a);
      mon(1, we_b, addr_b, din_b, done_b, err_b, hold_b);
    end
  end

  // Present one byte at a negedge and hold it until both instances take it
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    dl_valid = 1'b1;
    dl_data  = b;
    while (!(rdy_a && rdy_b) && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!(rdy_a && rdy_b)) fail("ready_timeout");
    @(negedge clk);
  endtask

  task automatic run_load(input logic [7:0] file[$], input int gap_pct);
    int w = 0;
    model(0, file);
    model(1, file);
    @(negedge clk);
    dl_active = 1'b1;
    @(negedge clk);
    for (int i = 0; i < file.size(); i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        dl_valid = 1'b0;
        @(negedge clk);
      end
      send_byte(file[i]);
      if (i == 0) check("hold_during_load", 32'(hold_a), 32'd1);
    end
    dl_valid  = 1'b0;
    dl_active = 1'b0;
    while ((exp_done_a.size() != 0 || exp_done_b.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (exp_done_a.size() != 0 || exp_done_b.size() != 0) fail("done_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'({rdy_a, rdy_b}), 32'd0);
    check({tag, "_we"},    32'({we_a, we_b}), 32'd0);
    check({tag, "_addr"},  32'({addr_a, addr_b}), 32'd0);
    check({tag, "_din"},   32'({din_a, din_b}), 32'd0);
    check({tag, "_hold"},  32'({hold_a, hold_b}), 32'd0);
    check({tag, "_done"},  32'({done_a, done_b}), 32'd0);
    check({tag, "_err"},   32'({err_a, err_b}), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  f[$];
    logic [15:0] la;
    int          nb;
    wr_t         w;

    reset_n   = 1'b0;
    dl_active = 1'b0;
    dl_valid  = 1'b0;
    dl_data   = 8'h00;
    #2;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    f = {8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    run_load(f, 0);
    f = {8'hFE, 8'h3F, 8'h11, 8'h22, 8'h33};
    run_load(f, 0);
    f = {8'h01};
    run_load(f, 0);
    check("short_hold", 32'(hold_a), 32'd0);

    f = {8'h00, 8'h04};
    for (int i = 0; i < 256; i++) f.push_back(8'($urandom));
    run_load(f, 0);

    f = {8'h00, 8'h10, 8'h55};
    run_load(f, 0);

    // Reset in the middle of a payload: only the ten data writes may appear
    for (int i = 0; i < 10; i++) begin
      w.addr = 14'h0400 + 14'(i);
      w.data = 8'(8'h60 + i);
      exp_wr_a.push_back(w);
      exp_wr_b.push_back(w);
    end
    @(negedge clk);
    dl_active = 1'b1;
    @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h04);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h60 + i));
    dl_valid = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    dl_active = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("midreset_wr_left", exp_wr_a.size() + exp_wr_b.size(), 0);
    repeat (3) @(negedge clk);
    f = {8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    run_load(f, 0);

    // Random files, biased toward the RAM top and the 16-bit wrap
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 3))
        0:       la = 16'($urandom_range(0, 'h3FFF));
        1:       la = 16'($urandom_range('h3FF0, 'h3FFF));
        2:       la = 16'($urandom_range('hFFF8, 'hFFFF));
        default: la = 16'($urandom);
      endcase
      nb = $urandom_range(0, 26);
      f.delete();
      if (nb >= 1) f.push_back(la[7:0]);
      if (nb >= 2) f.push_back(la[15:8]);
      for (int i = 2; i < nb; i++) f.push_back(8'($urandom));
      run_load(f, 30);
    end

    check("final_wr_left_a", exp_wr_a.size(), 0);
    check("final_wr_left_b", exp_wr_b.size(), 0);
    check("final_done_left", exp_done_a.size() + exp_done_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
